prbs7_checker: RTL and testbench

- Serial PRBS7 checker: receiving end of the XNOR-form PRBS7 generator (x^7 + x^6 + 1) used for ADPLL/DCO test pattern links.
- Acquires sequence alignment from the received bit stream, declares lock, flags per-bit errors, keeps a saturating error count.
- Sits after the serial sampler in the ADPLL test path; outputs go to status registers.

---
 rtl/prbs7_checker.sv | 133 +++++++++++++
 tb/tb_prbs7_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - serial PRBS7 (x^7+x^6+1, XNOR form) checker with lock FSM and error counter
module prbs7_checker #(
  parameter int LOCK_CNT    = 32,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr,
  output logic             locked,
  output logic             bit_err,
  output logic             err_seen,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_e;

  localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERRS);

  state_e             state_q, state_d;
  logic [6:0]         s_q, s_d;
  logic [2:0]         fc_q, fc_d;
  logic [7:0]         mc_q, mc_d;
  logic [7:0]         rc_q, rc_d;
  logic [3:0]         mm_q, mm_d;
  logic               bit_err_q, bit_err_d;
  logic               err_seen_q, err_seen_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               p;

  assign p = ~(s_q[6] ^ s_q[5]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      s_q        <= '0;
      fc_q       <= '0;
      mc_q       <= '0;
      rc_q       <= '0;
      mm_q       <= '0;
      bit_err_q  <= 1'b0;
      err_seen_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      fc_q       <= fc_d;
      mc_q       <= mc_d;
      rc_q       <= rc_d;
      mm_q       <= mm_d;
      bit_err_q  <= bit_err_d;
      err_seen_q <= err_seen_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    fc_d       = fc_q;
    mc_d       = mc_q;
    rc_d       = rc_q;
    mm_d       = mm_q;
    bit_err_d  = 1'b0;
    err_seen_d = err_seen_q;
    err_cnt_d  = err_cnt_q;

    if (din_valid) begin
      case (state_q)
        FILL: begin
          s_d  = {s_q[5:0], din};
          fc_d = fc_q + 3'd1;
          if (fc_q == 3'd6) begin
            state_d = SEARCH;
            fc_d    = '0;
            mc_d    = '0;
          end
        end
        SEARCH: begin
          s_d = {s_q[5:0], din};
          // all-ones is the XNOR lock-up state: never count matches there
          if (din == p && s_q != 7'h7F) begin
            mc_d = mc_q + 8'd1;
            if (mc_q + 8'd1 == LOCK_N) begin
              state_d = LOCKED;
              mc_d    = '0;
              mm_d    = '0;
              rc_d    = '0;
            end
          end else begin
            mc_d = '0;
          end
        end
        LOCKED: begin
          // free-run on the prediction so a bad bit does not corrupt later ones
          s_d = {s_q[5:0], p};
          if (din != p) begin
            bit_err_d  = 1'b1;
            err_seen_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            rc_d = '0;
            mm_d = mm_q + 4'd1;
            if (mm_q + 4'd1 == UNLOCK_N) begin
              state_d = SEARCH;
              mc_d    = '0;
            end
          end else begin
            rc_d = rc_q + 8'd1;
            if (rc_q + 8'd1 == LOCK_N) begin
              rc_d = '0;
              mm_d = '0;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end

    if (clr) begin
      err_cnt_d  = '0;
      err_seen_d = 1'b0;
    end
  end

  assign locked   = (state_q == LOCKED);
  assign bit_err  = bit_err_q;
  assign err_seen = err_seen_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - directed bench for prbs7_checker
module tb_prbs7_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        clr = 1'b0;
  logic        locked, bit_err, err_seen;
  logic [15:0] err_cnt;
  logic        sat_locked, sat_bit_err, sat_err_seen;
  logic [2:0]  sat_err_cnt;

  logic [6:0]  gs;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  prbs7_checker u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .locked(locked), .bit_err(bit_err), .err_seen(err_seen), .err_cnt(err_cnt)
  );

  prbs7_checker #(.LOCK_CNT(32), .UNLOCK_ERRS(15), .ERR_W(3)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .locked(sat_locked), .bit_err(sat_bit_err), .err_seen(sat_err_seen), .err_cnt(sat_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic c);
    din = d; din_valid = v; clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic flip, input logic c);
    logic b;
    b  = ~(gs[6] ^ gs[5]);
    gs = {gs[5:0], b};
    step(b ^ flip, 1'b1, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 1'b0; din_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    gs  = '0;
  endtask

  task automatic acquire(input string tag);
    repeat (38) send(1'b0, 1'b0);
    check({tag, "_locked_at_38"}, 32'(locked), 32'd0);
    send(1'b0, 1'b0);
    check({tag, "_locked_at_39"}, 32'(locked), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] first;
    logic       any_err, any_lock, dropped;
    logic       b;

    // reset state
    @(negedge clk);
    check("rst_locked",   32'(locked),   32'd0);
    check("rst_bit_err",  32'(bit_err),  32'd0);
    check("rst_err_seen", 32'(err_seen), 32'd0);
    check("rst_err_cnt",  32'(err_cnt),  32'd0);
    rst = 1'b0;

    // generator from zero seed starts 1111110
    gs = '0;
    first = '0;
    for (int i = 0; i < 7; i++) begin
      b = ~(gs[6] ^ gs[5]);
      gs = {gs[5:0], b};
      first = {first[5:0], b};
    end
    check("gen_first7", 32'(first), 32'b1111110);
    gs = '0;

    // clean stream
    acquire("clean");
    any_err = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      send(1'b0, 1'b0);
      any_err |= bit_err;
      dropped |= ~locked;
    end
    check("clean_bit_err", 32'(any_err), 32'd0);
    check("clean_dropped", 32'(dropped), 32'd0);
    check("clean_err_cnt", 32'(err_cnt), 32'd0);

    // single flip
    repeat (49) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("single_bit_err",  32'(bit_err),  32'd1);
    check("single_err_cnt",  32'(err_cnt),  32'd1);
    check("single_err_seen", 32'(err_seen), 32'd1);
    check("single_locked",   32'(locked),   32'd1);
    send(1'b0, 1'b0);
    check("single_pulse_end", 32'(bit_err), 32'd0);
    any_err = 1'b0;
    repeat (200) begin
      send(1'b0, 1'b0);
      any_err |= bit_err;
    end
    check("single_no_propagate", 32'(any_err), 32'd0);
    check("single_err_cnt_hold", 32'(err_cnt), 32'd1);

    // clear, then burst of 4 flips within 10 bits
    step(1'b0, 1'b0, 1'b1);
    check("clr_err_cnt",  32'(err_cnt),  32'd0);
    check("clr_err_seen", 32'(err_seen), 32'd0);
    check("clr_locked",   32'(locked),   32'd1);
    for (int k = 0; k < 3; k++) begin
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
    end
    check("burst_locked_before_4th", 32'(locked), 32'd1);
    send(1'b1, 1'b0);
    check("burst_err_cnt",  32'(err_cnt), 32'd4);
    check("burst_bit_err",  32'(bit_err), 32'd1);
    check("burst_unlocked", 32'(locked),  32'd0);
    repeat (31) send(1'b0, 1'b0);
    check("relock_at_31", 32'(locked), 32'd0);
    send(1'b0, 1'b0);
    check("relock_at_32", 32'(locked), 32'd1);

    // gapped valid: lock timing counted in valid bits only
    do_reset();
    for (int i = 0; i < 39; i++) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      send(1'b0, 1'b0);
      if (i == 37) check("gap_locked_at_38", 32'(locked), 32'd0);
    end
    check("gap_locked_at_39", 32'(locked), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("gap_err_cnt", 32'(err_cnt), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    check("gap_invalid_no_pulse", 32'(bit_err), 32'd0);
    send(1'b1, 1'b1);
    check("clr_err_bit_err",  32'(bit_err),  32'd1);
    check("clr_err_err_cnt",  32'(err_cnt),  32'd0);
    check("clr_err_err_seen", 32'(err_seen), 32'd0);

    // saturation: ERR_W=3 instance holds at 7 after 10 errors
    do_reset();
    acquire("sat");
    for (int i = 0; i < 10; i++) begin
      repeat (40) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
    end
    check("sat_err_cnt",   32'(sat_err_cnt), 32'd7);
    check("sat_bit_err",   32'(sat_bit_err), 32'd1);
    check("sat_main_cnt",  32'(err_cnt),     32'd10);
    check("sat_main_lock", 32'(locked),      32'd1);

    // asynchronous reset mid-lock with err_cnt=5
    do_reset();
    acquire("mid");
    for (int i = 0; i < 5; i++) begin
      repeat (40) send(1'b0, 1'b0);
      send(1'b1, 1'b0);
    end
    check("mid_err_cnt_pre", 32'(err_cnt), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("async_locked",   32'(locked),   32'd0);
    check("async_bit_err",  32'(bit_err),  32'd0);
    check("async_err_seen", 32'(err_seen), 32'd0);
    check("async_err_cnt",  32'(err_cnt),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    acquire("reacq");

    // stuck-at-1 never locks
    do_reset();
    any_lock = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step(1'b1, 1'b1, 1'b0);
      any_lock |= locked;
    end
    check("stuck1_locked",  32'(any_lock), 32'd0);
    check("stuck1_err_cnt", 32'(err_cnt),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
